enemy_spawn_sched: RTL
======================

Name: enemy_spawn_sched

Overview:
Central spawn controller for the three enemy pools (small, medium, large). Runs on clk_run and decides when to spawn, which type, which free slot, what x position and what speed code. It emits a one-cycle spawn command to the owning pool, replacing each pool's free-running trigger counter. Difficulty level is derived from the player's score and sets spawn period, type mix and speed.

Parameters:
RAND_W, 16, width of random input
X_W, 9, x position width
SCREEN_W, 480, display width in pixels
E1_W / E2_W / E3_W, 57 / 69 / 169, sprite widths of types 1/2/3
N1 / N2 / N3, 8 / 4 / 2, slot count per pool
PERIOD0..PERIOD3, 2000 / 1500 / 1000 / 700, clk_run ticks between spawn attempts per level
LV1_SCORE / LV2_SCORE / LV3_SCORE, 20 / 60 / 150, score thresholds for levels 1/2/3

Ports:
clk_run  in  1  game logic clock
rst  in  1  asynchronous active-high reset
en_i  in  1  game running; low = pause
restart_i  in  1  sync pulse; returns level to 0 and the FSM to IDLE
rand_i  in  RAND_W  LFSR value
score_i  in  16  current score
free1_i / free2_i / free3_i  in  N1 / N2 / N3  per-slot free flags (1 = slot not visible)
spawn_o  out  1  one-cycle spawn strobe
spawn_type_o  out  2  1 = small, 2 = medium, 3 = large
spawn_idx_o  out  3  slot index in the chosen pool
spawn_x_o  out  X_W  left x coordinate
spawn_speed_o  out  2  00 stop, 01 low, 11 middle, 10 high
level_o  out  2  current difficulty level
miss_o  out  1  one-cycle pulse when an attempt found no free slot

Behaviour:
- Reset is asynchronous, active-high, on rst. Clock is clk_run.
- Reset values: all outputs 0, FSM in IDLE, interval counter 0, level 0.
- Level register:
  - Each cycle, level becomes max(level, f(score_i)); f = 3 if score ≥ LV3_SCORE, 2 if ≥ LV2_SCORE, 1 if ≥ LV1_SCORE, else 0.
  - Level never decreases except on restart_i or rst.
- FSM states are IDLE, PICK, ISSUE.
- IDLE:
  - If en_i = 1, the counter increments.
  - When the counter equals PERIODlevel−1, clear it, latch rand_i into r, and go to PICK.
  - If en_i = 0, the counter holds.
  - A level change mid-count takes effect at the next compare; the counter is not cleared.
- PICK (one cycle), type from r[2:0]:
  - Level 0: always type 1.
  - Level 1: r[1:0] = 3 gives type 2, else type 1.
  - Level 2: 0 gives type 3; 1–2 give type 2; else type 1.
  - Level 3: 0–1 give type 3; 2–4 give type 2; else type 1.
- Slot selection:
  - The slot is the lowest-index set bit of the chosen pool's free vector.
  - If that pool has no free slot, fall back to type 1.
  - If type 1 also has no free slot, pulse miss_o for one cycle and return to IDLE.
- X position:
  - lim = SCREEN_W − E_W of the final type; xr = r[X_W+2:3].
  - x = xr if xr ≤ lim, else xr − lim − 1. The result is always ≤ lim.
- Speed code:
  - Level 0: 01.
  - Level 1: r[X_W+3] ? 11 : 01.
  - Level 2: 11.
  - Level 3: r[X_W+3] ? 10 : 11.
- ISSUE:
  - spawn_o = 1 for exactly one cycle, with type, idx, x and speed registered and stable in that cycle.
  - Next state is IDLE.
  - Latency from the counter hit to spawn_o is 2 cycles (PICK, ISSUE).
- Pause and restart:
  - en_i = 0 while in PICK returns the FSM to IDLE with no spawn and no miss.
  - ISSUE always completes.
  - restart_i has priority over all state transitions: FSM goes to IDLE, counter to 0, level to 0; spawn_o is not asserted that cycle.
- Free vectors are sampled only in PICK. A pool must not clear its free bit later than one cycle after spawn_o.

Optional Feature:
SPAWN_BURST_EN
- Defined:
  - At level 3, an ISSUE of type 1 is followed by a second PICK forced to type 1.
  - Second spawn position is x = lim1 − previous x (the mirrored position), with the same speed code.
  - Slot is the lowest free bit, excluding the slot just issued.
  - If no slot is available, the burst is silently dropped (no miss_o).
  - At most one extra spawn per attempt.
- Undefined: ISSUE always returns to IDLE.

Test Plan:
1. Reset, en_i = 1, score 0, all slots free, PERIOD0 = 2000 → spawn_o at cycle 2002 after reset release; type 1, idx 0, speed 01, spawn_x_o ≤ 423.
2. rand_i forcing xr = 511 for type 3 (lim 311) → spawn_x_o = 199; xr = 311 → 311.
3. score_i = 150, r[2:0] = 0, free3_i = 00 → falls back to type 1; also set free1_i = 0 → miss_o pulses, no spawn_o.
4. score_i steps 0 → 65 → 10 → level_o goes 0 → 2 and stays 2; restart_i pulse → level_o = 0 and counter restarts.
5. en_i low for 500 cycles mid-interval → spawn delayed by exactly 500 cycles; en_i dropped during PICK → no spawn.
6. SPAWN_BURST_EN, level 3, type 1 at x = 100 → second spawn_o 2 cycles later with x = 323 and idx = next free slot.

Source files
------------

// File: rtl/enemy_spawn_sched.sv
// Spawn scheduler for the three enemy pools: a level-scaled interval, then PICK and ISSUE, so the spawn strobe follows a counter hit by 2 cycles.
// The optional SPAWN_BURST_EN macro adds one mirrored type-1 follow-up spawn at level 3.
module enemy_spawn_sched #(
    parameter int RAND_W    = 16,
    parameter int X_W       = 9,
    parameter int SCREEN_W  = 480,
    parameter int E1_W      = 57,
    parameter int E2_W      = 69,
    parameter int E3_W      = 169,
    parameter int N1        = 8,
    parameter int N2        = 4,
    parameter int N3        = 2,
    parameter int PERIOD0   = 2000,
    parameter int PERIOD1   = 1500,
    parameter int PERIOD2   = 1000,
    parameter int PERIOD3   = 700,
    parameter int LV1_SCORE = 20,
    parameter int LV2_SCORE = 60,
    parameter int LV3_SCORE = 150
) (
    input  logic              clk_run,
    input  logic              rst,
    input  logic              en_i,
    input  logic              restart_i,
    input  logic [RAND_W-1:0] rand_i,
    input  logic [15:0]       score_i,
    input  logic [N1-1:0]     free1_i,
    input  logic [N2-1:0]     free2_i,
    input  logic [N3-1:0]     free3_i,
    output logic              spawn_o,
    output logic [1:0]        spawn_type_o,
    output logic [2:0]        spawn_idx_o,
    output logic [X_W-1:0]    spawn_x_o,
    output logic [1:0]        spawn_speed_o,
    output logic [1:0]        level_o,
    output logic              miss_o
);
    localparam int CNT_W = 16;
    localparam logic [X_W-1:0] LIM1 = X_W'(SCREEN_W - E1_W);
    localparam logic [X_W-1:0] LIM2 = X_W'(SCREEN_W - E2_W);
    localparam logic [X_W-1:0] LIM3 = X_W'(SCREEN_W - E3_W);

    typedef enum logic [1:0] {IDLE = 2'd0, PICK = 2'd1, ISSUE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, period_m1;
    logic [1:0]       level_q, level_d, score_lvl;
    logic [X_W+3:0]   r_q, r_d;
    logic [1:0]       type_q, type_d, speed_q, speed_d;
    logic [2:0]       idx_q, idx_d;
    logic [X_W-1:0]   x_q, x_d;
    logic             miss_q, miss_d;
    logic             burst_q;

    logic [1:0]     pref_type, pick_type, pick_speed;
    logic [7:0]     f1_avail, pref_vec;
    logic [3:0]     hit_pref, hit1, pick_hit;
    logic [X_W-1:0] xr, lim, x_wrap, pick_x;
    logic           unused_rand_bits;

    assign unused_rand_bits = ^rand_i[RAND_W-1:X_W+4];

    // Returns {found, index} of the lowest set bit.
    function automatic logic [3:0] first_free(input logic [7:0] v);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) res = {1'b1, 3'(i)};
        end
        return res;
    endfunction

    always_comb begin
        score_lvl = 2'd0;
        if (score_i >= 16'(LV3_SCORE))      score_lvl = 2'd3;
        else if (score_i >= 16'(LV2_SCORE)) score_lvl = 2'd2;
        else if (score_i >= 16'(LV1_SCORE)) score_lvl = 2'd1;
        case (level_q)
            2'd0:    period_m1 = CNT_W'(PERIOD0 - 1);
            2'd1:    period_m1 = CNT_W'(PERIOD1 - 1);
            2'd2:    period_m1 = CNT_W'(PERIOD2 - 1);
            default: period_m1 = CNT_W'(PERIOD3 - 1);
        endcase
    end

    always_comb begin
        pref_type = 2'd1;
        case (level_q)
            2'd1:    pref_type = (r_q[1:0] == 2'd3) ? 2'd2 : 2'd1;
            2'd2:    pref_type = (r_q[2:0] == 3'd0) ? 2'd3 : (r_q[2:0] <= 3'd2) ? 2'd2 : 2'd1;
            2'd3:    pref_type = (r_q[2:0] <= 3'd1) ? 2'd3 : (r_q[2:0] <= 3'd4) ? 2'd2 : 2'd1;
            default: pref_type = 2'd1;
        endcase
        if (burst_q) pref_type = 2'd1;

        // The follow-up spawn must not reuse the slot whose free bit may still be stale.
        f1_avail = 8'(free1_i) & ~(burst_q ? (8'd1 << idx_q) : 8'd0);
        case (pref_type)
            2'd2:    pref_vec = 8'(free2_i);
            2'd3:    pref_vec = 8'(free3_i);
            default: pref_vec = f1_avail;
        endcase
        hit_pref = first_free(pref_vec);
        hit1     = first_free(f1_avail);
        if (hit_pref[3]) begin
            pick_type = pref_type;
            pick_hit  = hit_pref;
        end else begin
            pick_type = 2'd1;
            pick_hit  = hit1;
        end

        case (pick_type)
            2'd2:    lim = LIM2;
            2'd3:    lim = LIM3;
            default: lim = LIM1;
        endcase
        xr     = r_q[X_W+2:3];
        x_wrap = (xr <= lim) ? xr : xr - lim - 1'b1;
        pick_x = burst_q ? LIM1 - x_q : x_wrap;

        case (level_q)
            2'd0:    pick_speed = 2'b01;
            2'd1:    pick_speed = r_q[X_W+3] ? 2'b11 : 2'b01;
            2'd2:    pick_speed = 2'b11;
            default: pick_speed = r_q[X_W+3] ? 2'b10 : 2'b11;
        endcase
        if (burst_q) pick_speed = speed_q;
    end

`ifdef SPAWN_BURST_EN
    logic burst_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        type_d  = type_q;
        idx_d   = idx_q;
        x_d     = x_q;
        speed_d = speed_q;
        miss_d  = 1'b0;
        level_d = (score_lvl > level_q) ? score_lvl : level_q;
`ifdef SPAWN_BURST_EN
        burst_d = burst_q;
`endif
        case (state_q)
            IDLE: begin
                if (en_i) begin
                    if (cnt_q == period_m1) begin
                        cnt_d   = '0;
                        r_d     = rand_i[X_W+3:0];
                        state_d = PICK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PICK: begin
                if (!en_i) begin
                    state_d = IDLE;
`ifdef SPAWN_BURST_EN
                    burst_d = 1'b0;
`endif
                end else if (pick_hit[3]) begin
                    state_d = ISSUE;
                    type_d  = pick_type;
                    idx_d   = pick_hit[2:0];
                    x_d     = pick_x;
                    speed_d = pick_speed;
                end else begin
                    state_d = IDLE;
                    miss_d  = ~burst_q;
`ifdef SPAWN_BURST_EN
                    burst_d = 1'b0;
`endif
                end
            end
            ISSUE: begin
                state_d = IDLE;
`ifdef SPAWN_BURST_EN
                burst_d = 1'b0;
                if (level_q == 2'd3 && type_q == 2'd1 && !burst_q) begin
                    state_d = PICK;
                    burst_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        if (restart_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            level_d = 2'd0;
            miss_d  = 1'b0;
`ifdef SPAWN_BURST_EN
            burst_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 2'd0;
            r_q     <= '0;
            type_q  <= 2'd0;
            idx_q   <= 3'd0;
            x_q     <= '0;
            speed_q <= 2'd0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            r_q     <= r_d;
            type_q  <= type_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            speed_q <= speed_d;
            miss_q  <= miss_d;
        end
    end

`ifdef SPAWN_BURST_EN
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) burst_q <= 1'b0;
        else     burst_q <= burst_d;
    end
`else
    assign burst_q = 1'b0;
`endif

    assign spawn_o       = (state_q == ISSUE) && !restart_i;
    assign spawn_type_o  = type_q;
    assign spawn_idx_o   = idx_q;
    assign spawn_x_o     = x_q;
    assign spawn_speed_o = speed_q;
    assign level_o       = level_q;
    assign miss_o        = miss_q;
endmodule
